// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Master drives the request; slave answers with data.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I multi-cycle fetch stage: PC, IR, imem handshake and IR decode.
// Faults are one-cycle pulses; seq_error is sticky until reset.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter int              TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic            pc_update,
    input  logic [1:0]      pc_select,
    input  logic [XLEN-1:0] alu_result,
    fetch_unit_if.master    imem,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            busy,
    output logic            misaligned_fault,
    output logic            bus_fault,
    output logic            seq_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            iv_q, iv_d;
    logic            mis_q, mis_d;
    logic            bus_q, bus_d;
    logic            seq_q, seq_d;
    logic [XLEN-1:0] pc_upd;

    assign pc_plus4 = pc_q + XLEN'(4);

    // Bit 0 of a jump target is always dropped (JALR semantics).
    always_comb begin
        pc_upd = pc_q;
        unique case (pc_select)
            2'b00: pc_upd = alu_result & ~XLEN'(1);
            2'b01: pc_upd = pc_plus4;
            2'b10: pc_upd = pc_q;
            2'b11: pc_upd = TRAP_VEC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP;
            addr_q  <= RESET_PC;
            cnt_q   <= '0;
            iv_q    <= 1'b0;
            mis_q   <= 1'b0;
            bus_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            iv_q    <= iv_d;
            mis_q   <= mis_d;
            bus_q   <= bus_d;
            seq_q   <= seq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        iv_d    = 1'b0;
        mis_d   = 1'b0;
        bus_d   = 1'b0;
        seq_d   = seq_q;
        unique case (state_q)
            S_IDLE: begin
                if (pc_update) pc_d = pc_upd;
                // Alignment is judged on the PC the fetch will use.
                if (fetch_req) begin
                    if (pc_d[1:0] == 2'b00) begin
                        state_d = S_REQ;
                        addr_d  = pc_d;
                    end else begin
                        mis_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (fetch_req || pc_update) seq_d = 1'b1;
                if (imem.imem_req_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (fetch_req || pc_update) seq_d = 1'b1;
                if (imem.imem_rsp_valid) begin
                    ir_d    = imem.imem_rsp_data;
                    iv_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    bus_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign imem.imem_req_valid = (state_q == S_REQ);
    assign imem.imem_addr      = addr_q;

    assign instr_valid      = iv_q;
    assign misaligned_fault = mis_q;
    assign bus_fault        = bus_q;
    assign seq_error        = seq_q;
    assign busy             = (state_q != S_IDLE);
    assign pc               = pc_q;

    assign instr  = ir_q;
    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic is_i, is_s, is_b, is_u, is_j;

    assign is_i = (opcode == OP_LOAD) || (opcode == OP_IMM) ||
                  (opcode == OP_JALR) || (opcode == OP_SYSTEM) ||
                  (opcode == OP_FENCE);
    assign is_s = (opcode == OP_STORE);
    assign is_b = (opcode == OP_BRANCH);
    assign is_u = (opcode == OP_LUI) || (opcode == OP_AUIPC);
    assign is_j = (opcode == OP_JAL);

    always_comb begin
        imm = '0;
        unique case (1'b1)
            is_i: imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
            is_s: imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            is_b: imm = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7],
                         ir_q[30:25], ir_q[11:8], 1'b0};
            is_u: imm = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
            is_j: imm = {{(XLEN-21){ir_q[31]}}, ir_q[31], ir_q[19:12],
                         ir_q[20], ir_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IR loads and fault pulses
// are queued at stimulus time and matched against DUT pulses.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_update = 1'b0;
    logic [1:0]  pc_select = 2'b10;
    logic [31:0] alu_result = '0;

    logic        instr_valid, busy, misaligned_fault, bus_fault, seq_error;
    logic [31:0] instr, imm, pc, pc_plus4;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;

    fetch_unit_if #(.XLEN(32)) mem ();

    fetch_unit #(
        .XLEN    (32),
        .RESET_PC(32'h0000_0000),
        .TRAP_VEC(32'h0000_0100),
        .TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .pc_update       (pc_update),
        .pc_select       (pc_select),
        .alu_result      (alu_result),
        .imem            (mem),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .opcode          (opcode),
        .funct3          (funct3),
        .funct7          (funct7),
        .rd              (rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .imm             (imm),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .busy            (busy),
        .misaligned_fault(misaligned_fault),
        .bus_fault       (bus_fault),
        .seq_error       (seq_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } evt_t;

    localparam logic [2:0] K_IV  = 3'b001;
    localparam logic [2:0] K_MIS = 3'b010;
    localparam logic [2:0] K_BUS = 3'b100;

    evt_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    evt_t       mon_e;
    logic [2:0] mon_k;

    always @(negedge clk) begin
        mon_k = {bus_fault, misaligned_fault, instr_valid};
        if (mon_k != 3'b000) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(mon_k), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("sb_data", mon_k[0] ? instr : pc, mon_e.data);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        fetch_req = 1'b0;
        pc_update = 1'b0;
        mem.imem_req_ready = 1'b0;
        mem.imem_rsp_valid = 1'b0;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
    endtask

    task automatic fetch(input int rdly, input int rspdly,
                         input logic [31:0] d, input logic [31:0] a);
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_IV, data: d});
        tick();
        fetch_req = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            chk("hold_valid", 32'(mem.imem_req_valid), 32'h1);
            chk("hold_addr", mem.imem_addr, a);
            tick();
        end
        chk("req_valid", 32'(mem.imem_req_valid), 32'h1);
        chk("req_addr", mem.imem_addr, a);
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        for (int i = 0; i < rspdly; i++) begin
            chk("wait_valid", 32'(mem.imem_req_valid), 32'h0);
            tick();
        end
        mem.imem_rsp_valid = 1'b1;
        mem.imem_rsp_data  = d;
        tick();
        mem.imem_rsp_valid = 1'b0;
        chk("iv", 32'(instr_valid), 32'h1);
        chk("ir", instr, d);
    endtask

    logic [31:0] tbl_ins[9] = '{
        32'hFE112E23, 32'hFE208CE3, 32'h123452B7,
        32'h001000EF, 32'h002081B3, 32'hFFFFF517,
        32'hFFE08067, 32'h00812283, 32'hFFF00093
    };
    logic [31:0] tbl_imm[9] = '{
        32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
        32'h00000800, 32'h00000000, 32'hFFFFF000,
        32'hFFFFFFFE, 32'h00000008, 32'hFFFFFFFF
    };
    logic [31:0] tbl_op[9] = '{
        32'h23, 32'h63, 32'h37, 32'h6F, 32'h33,
        32'h17, 32'h67, 32'h03, 32'h13
    };

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [31:0] exp_pc;
        int          n;

        mem.imem_req_ready = 1'b0;
        mem.imem_rsp_valid = 1'b0;
        mem.imem_rsp_data  = '0;
        do_reset();

        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instr, 32'h00000013);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_reqv", 32'(mem.imem_req_valid), 32'h0);
        chk("rst_addr", mem.imem_addr, 32'h0);
        chk("rst_seq", 32'(seq_error), 32'h0);

        // Minimum-latency fetch: instr_valid three cycles after request.
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_IV, data: 32'h00A00093});
        tick();
        fetch_req = 1'b0;
        chk("lat_reqv", 32'(mem.imem_req_valid), 32'h1);
        chk("lat_addr", mem.imem_addr, 32'h0);
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        chk("lat_wait_reqv", 32'(mem.imem_req_valid), 32'h0);
        chk("lat_busy", 32'(busy), 32'h1);
        mem.imem_rsp_valid = 1'b1;
        mem.imem_rsp_data  = 32'h00A00093;
        tick();
        mem.imem_rsp_valid = 1'b0;
        chk("lat_iv", 32'(instr_valid), 32'h1);
        chk("lat_opcode", 32'(opcode), 32'h13);
        chk("lat_rd", 32'(rd), 32'h1);
        chk("lat_imm", imm, 32'd10);
        chk("lat_pc", pc, 32'h0);
        chk("lat_idle", 32'(busy), 32'h0);
        tick();
        chk("lat_iv_pulse", 32'(instr_valid), 32'h0);

        // Stalled request: address held while ready is low.
        fetch(5, 1, 32'hFFF00093, 32'h0);
        chk("stall_imm", imm, 32'hFFFFFFFF);

        exp_pc = 32'h0;
        for (int i = 0; i < 9; i++) begin
            pc_update = 1'b1;
            pc_select = 2'b01;
            tick();
            pc_update = 1'b0;
            exp_pc = exp_pc + 32'd4;
            chk("seq_pc", pc, exp_pc);
            fetch(0, i % 3, tbl_ins[i], exp_pc);
            chk("dec_imm", imm, tbl_imm[i]);
            chk("dec_op", 32'(opcode), tbl_op[i]);
        end

        fetch(0, 0, 32'h402081B3, exp_pc);
        chk("r_f7", 32'(funct7), 32'h20);
        chk("r_f3", 32'(funct3), 32'h0);
        chk("r_rd", 32'(rd), 32'h3);
        chk("r_rs1", 32'(rs1), 32'h1);
        chk("r_rs2", 32'(rs2), 32'h2);
        chk("r_imm", imm, 32'h0);

        pc_update = 1'b1;
        pc_select = 2'b11;
        tick();
        chk("trap_pc", pc, 32'h100);
        pc_select = 2'b10;
        tick();
        pc_update = 1'b0;
        chk("hold_pc", pc, 32'h100);

        // Response never arrives: bus_fault after TIMEOUT cycles in WAIT.
        do_reset();
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_BUS, data: 32'h0});
        tick();
        fetch_req = 1'b0;
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (bus_fault) break;
        end
        chk("bus_lat", 32'(n), 32'd4);
        chk("bus_ir", instr, 32'h00000013);
        chk("bus_busy", 32'(busy), 32'h0);

        // Odd target: bit 0 dropped, bit 1 kept, fetch faults.
        pc_update = 1'b1;
        pc_select = 2'b00;
        alu_result = 32'h0000_0207;
        tick();
        pc_update = 1'b0;
        chk("mis_pc", pc, 32'h206);
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_MIS, data: 32'h206});
        tick();
        fetch_req = 1'b0;
        chk("mis_pulse", 32'(misaligned_fault), 32'h1);
        chk("mis_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("mis_noreq", 32'(mem.imem_req_valid), 32'h0);
            tick();
        end
        chk("mis_pc_after", pc, 32'h206);

        // PC wrap combined with a same-cycle fetch.
        pc_update = 1'b1;
        pc_select = 2'b00;
        alu_result = 32'hFFFF_FFFC;
        tick();
        pc_update = 1'b0;
        chk("wrap_pc", pc, 32'hFFFFFFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        pc_update = 1'b1;
        pc_select = 2'b01;
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_IV, data: 32'h00500113});
        tick();
        pc_update = 1'b0;
        fetch_req = 1'b0;
        chk("wrap_pc0", pc, 32'h0);
        chk("wrap_addr", mem.imem_addr, 32'h0);
        chk("wrap_reqv", 32'(mem.imem_req_valid), 32'h1);
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        mem.imem_rsp_valid = 1'b1;
        mem.imem_rsp_data  = 32'h00500113;
        tick();
        mem.imem_rsp_valid = 1'b0;
        chk("wrap_ir", instr, 32'h00500113);

        // Commands while busy are dropped and flagged.
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_IV, data: 32'h123452B7});
        tick();
        fetch_req = 1'b0;
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        fetch_req = 1'b1;
        pc_update = 1'b1;
        pc_select = 2'b11;
        tick();
        fetch_req = 1'b0;
        pc_update = 1'b0;
        chk("seq_set", 32'(seq_error), 32'h1);
        chk("seq_pc", pc, 32'h0);
        mem.imem_rsp_valid = 1'b1;
        mem.imem_rsp_data  = 32'h123452B7;
        tick();
        mem.imem_rsp_valid = 1'b0;
        chk("seq_iv", 32'(instr_valid), 32'h1);
        chk("seq_pc_keep", pc, 32'h0);
        tick();
        tick();
        chk("seq_sticky", 32'(seq_error), 32'h1);
        chk("seq_idle", 32'(busy), 32'h0);

        // Reset mid-WAIT abandons the fetch; late response is ignored.
        fetch_req = 1'b1;
        sb.push_back(evt_t'{kind: K_IV, data: 32'hDEADBEEF});
        tick();
        fetch_req = 1'b0;
        mem.imem_req_ready = 1'b1;
        tick();
        mem.imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        sb.delete();
        rst = 1'b0;
        mem.imem_rsp_valid = 1'b1;
        mem.imem_rsp_data  = 32'hDEADBEEF;
        tick();
        mem.imem_rsp_valid = 1'b0;
        chk("abort_iv", 32'(instr_valid), 32'h0);
        chk("abort_ir", instr, 32'h00000013);
        chk("abort_seq", 32'(seq_error), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        tick();
        chk("abort_iv2", 32'(instr_valid), 32'h0);
        chk("abort_ir2", instr, 32'h00000013);

        tick();
        chk("sb_left", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the multi-cycle RV32I core, directly upstream of the control FSM.
- Owns the PC and instruction register (IR) and runs a request/response handshake with instruction memory.
- Decodes the IR fields (opcode, funct3, register indices, immediate) that the control FSM and datapath consume.
- Applies the control FSM's PC-select command to load the next PC.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- TRAP_VEC, 32'h0000_0100, PC target when pc_select=2'b11.
- TIMEOUT, 64, max cycles in WAIT before bus_fault (must fit 8-bit counter, 1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  start fetch at current PC (iMemRead from control)
- pc_update  in  1  load next PC per pc_select
- pc_select  in  2  00 ALU result, 01 PC+4, 10 hold, 11 TRAP_VEC
- alu_result  in  XLEN  branch/jump target from ALU
- imem_req_valid  out  1  memory request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  request address
- imem_rsp_valid  in  1  response data valid
- imem_rsp_data  in  32  fetched instruction
- instr_valid  out  1  one-cycle pulse: IR newly loaded
- instr  out  32  IR contents
- opcode  out  7  IR[6:0]
- funct3  out  3  IR[14:12]
- funct7  out  7  IR[31:25]
- rd, rs1, rs2  out  5 each  IR[11:7], IR[19:15], IR[24:20]
- imm  out  XLEN  sign-extended immediate for the IR format
- pc  out  XLEN  current PC
- pc_plus4  out  XLEN  pc+4, modulo 2^XLEN
- busy  out  1  state != IDLE
- misaligned_fault  out  1  one-cycle pulse
- bus_fault  out  1  one-cycle pulse
- seq_error  out  1  sticky; cleared only by rst

Behaviour:
- Reset values:
  - pc = RESET_PC; IR = 32'h0000_0013 (NOP).
  - State IDLE; timeout counter 0.
  - All pulse outputs and imem_req_valid 0; seq_error 0; imem_addr = RESET_PC.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - fetch_req with pc[1:0]==0: go to REQ next cycle; imem_addr registered from the PC value in effect after any same-cycle pc_update.
  - fetch_req with pc[1:0]!=0: misaligned_fault pulses next cycle; stay in IDLE; no memory request issued.
- REQ:
  - imem_req_valid=1; imem_addr held stable until imem_req_valid & imem_req_ready.
  - On that handshake cycle: go to WAIT; counter cleared.
- WAIT:
  - imem_req_valid=0.
  - imem_rsp_valid: IR <= imem_rsp_data; instr_valid=1 on the next cycle only; go to IDLE.
  - Otherwise counter increments. At counter==TIMEOUT-1 with no response: bus_fault pulses next cycle, go to IDLE, IR unchanged.
- imem_rsp_valid outside WAIT (including after reset aborts a fetch) is ignored.
- Minimum latency: fetch_req at cycle N, ready=1 at N+1, rsp_valid at N+2, instr_valid at N+3.
- pc_update (honoured only in IDLE), registered in the same cycle:
  - 00: pc <= {alu_result[XLEN-1:1],1'b0} (JALR bit-0 clear). pc[1]=1 is legal here and faults on the next fetch_req.
  - 01: pc <= pc_plus4, wrapping 32'hFFFF_FFFC -> 0.
  - 10: pc unchanged.
  - 11: pc <= TRAP_VEC.
- Simultaneous fetch_req + pc_update in IDLE: both accepted; the fetch uses the updated PC.
- fetch_req or pc_update while busy: ignored (PC and FSM unaffected) and seq_error set.
- Decode outputs are combinational from IR and stable between instr_valid pulses.
- imm by opcode:
  - I (LOAD, IMM, JALR, SYSTEM, FENCE): sext IR[31:20].
  - S: sext {IR[31:25],IR[11:7]}.
  - B: sext {IR[31],IR[7],IR[30:25],IR[11:8],0}.
  - U (LUI, AUIPC): {IR[31:12],12'b0}.
  - J: sext {IR[31],IR[19:12],IR[20],IR[30:21],0}.
  - ART/other: 0.
- rst asserted in any state: next cycle all reset values apply; an in-flight request is abandoned; no pulses.

Test Plan:
- Reset then fetch_req; ready=1 at cycle 1, rsp_valid with 32'h00A00093 at cycle 2 -> instr_valid at cycle 3, opcode=7'h13, rd=1, imm=10, pc=0.
- Hold ready=0 for 5 cycles in REQ -> imem_req_valid high and imem_addr=0 stable throughout; handshake on cycle 6; response returned -> IR loaded.
- TIMEOUT=4, no rsp_valid -> bus_fault pulse exactly 4 cycles after entering WAIT; IR still 32'h00000013; busy=0.
- pc_update with pc_select=00, alu_result=32'h0000_0206, then fetch_req -> misaligned_fault pulse; imem_req_valid never asserted; pc=32'h206.
- pc=32'hFFFF_FFFC, pc_update with pc_select=01 -> pc=0. Same cycle as fetch_req -> imem_addr=0.
- fetch_req and pc_update during WAIT -> seq_error=1 and stays set; PC unchanged. rst asserted mid-WAIT with a late rsp_valid -> no instr_valid; IR=NOP.
